// File: rtl/nco_cfg_ctrl.sv
// DDS (NCO) config-channel sequencer: builds {POFF, PINC} beats from base_inc plus a
// shifted loop correction, coalesces updates while busy, and gates the NCO output until settled.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for the first enable to launch the initial beat
// ST_SEND  | cfg_tvalid high, tdata frozen until the DDS accepts it
// ST_SETTLE| beat accepted, counting down the DDS pipeline latency
// ST_RUN   | NCO output reflects the last beat; pending updates relaunch a beat
module nco_cfg_ctrl #(
  parameter int PHASE_W    = 32,
  parameter int CORR_W     = 16,
  parameter int CORR_SHIFT = 8,
  parameter int SETTLE     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [PHASE_W-1:0]   base_inc,
  input  logic [CORR_W-1:0]    corr,
  input  logic                 corr_vld,
  input  logic [PHASE_W-1:0]   poff,
  input  logic                 poff_vld,
  output logic [2*PHASE_W-1:0] cfg_tdata,
  output logic                 cfg_tvalid,
  input  logic                 cfg_tready,
  output logic                 nco_en,
  output logic                 settled,
  output logic                 busy
);

  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CORR_W-1:0]  corr_q;
  logic [PHASE_W-1:0] poff_q;
  logic               pend_q;

  logic [CORR_W-1:0]         corr_nx;
  logic [PHASE_W-1:0]        poff_nx;
  logic signed [PHASE_W-1:0] corr_ext;
  logic [PHASE_W-1:0]        pinc_nx;
  logic                      strobe;

  // A strobe arriving in the launch cycle is folded into the beat being built.
  assign corr_nx  = corr_vld ? corr : corr_q;
  assign poff_nx  = poff_vld ? poff : poff_q;
  assign strobe   = corr_vld | poff_vld;
  assign corr_ext = PHASE_W'($signed(corr_nx));
  assign pinc_nx  = base_inc + PHASE_W'(corr_ext <<< CORR_SHIFT);

  assign nco_en = settled & enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      corr_q     <= '0;
      poff_q     <= '0;
      pend_q     <= 1'b0;
      cfg_tdata  <= '0;
      cfg_tvalid <= 1'b0;
      settled    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      corr_q <= corr_nx;
      poff_q <= poff_nx;
      if (strobe) pend_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (enable) begin
            cfg_tdata  <= {poff_nx, pinc_nx};
            cfg_tvalid <= 1'b1;
            pend_q     <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SEND;
          end
        end

        // Handshake completes regardless of enable so a raised tvalid is never withdrawn.
        ST_SEND: begin
          if (cfg_tready) begin
            cfg_tvalid <= 1'b0;
            cnt        <= CNT_LOAD;
            state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (enable) begin
            if (cnt == '0) begin
              settled <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_RUN;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (enable && (pend_q || strobe)) begin
            cfg_tdata  <= {poff_nx, pinc_nx};
            cfg_tvalid <= 1'b1;
            pend_q     <= 1'b0;
            settled    <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SEND;
          end
        end

        default: begin
          state      <= ST_IDLE;
          cfg_tvalid <= 1'b0;
          settled    <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_cfg_ctrl.sv
// Self-checking bench for nco_cfg_ctrl: directed scenarios plus randomized strobes,
// beats checked against an arithmetic model of the config word.
module tb_nco_cfg_ctrl;

  localparam int PW = 32;
  localparam int CW = 16;
  localparam int SH = 8;
  localparam int ST = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] base_inc = '0;
  logic [CW-1:0] corr = '0;
  logic          corr_vld = 1'b0;
  logic [PW-1:0] poff = '0;
  logic          poff_vld = 1'b0;
  logic          cfg_tready = 1'b0;
  logic [2*PW-1:0] cfg_tdata;
  logic          cfg_tvalid;
  logic          nco_en;
  logic          settled;
  logic          busy;

  int tests = 0;
  int fails = 0;

  logic [CW-1:0]   m_corr = '0;
  logic [PW-1:0]   m_poff = '0;
  logic [2*PW-1:0] exp_beat = '0;
  logic [2*PW-1:0] last_hs = '0;
  logic            prev_v = 1'b0;
  int              n_acc = 0;

  nco_cfg_ctrl #(.PHASE_W(PW), .CORR_W(CW), .CORR_SHIFT(SH), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .base_inc(base_inc),
    .corr(corr), .corr_vld(corr_vld), .poff(poff), .poff_vld(poff_vld),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .nco_en(nco_en), .settled(settled), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*PW-1:0] model_beat(input logic [PW-1:0] b,
                                                 input logic [CW-1:0] c,
                                                 input logic [PW-1:0] p);
    longint sum;
    sum = longint'(b) + longint'($signed(c)) * (longint'(1) << SH);
    return {p, sum[PW-1:0]};
  endfunction

  always @(posedge clk) begin
    if (rst_n && cfg_tvalid && cfg_tready) begin
      n_acc++;
      last_hs = cfg_tdata;
    end
  end

  // Each new beat must carry the latest strobed values; it must then hold still.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (cfg_tvalid && !prev_v) begin
        exp_beat = model_beat(base_inc, m_corr, m_poff);
        tests++;
        if (cfg_tdata !== exp_beat) begin
          fails++;
          $display("FAIL beat_data: got %h expected %h", cfg_tdata, exp_beat);
        end
      end else if (cfg_tvalid) begin
        tests++;
        if (cfg_tdata !== exp_beat) begin
          fails++;
          $display("FAIL beat_stable: got %h expected %h", cfg_tdata, exp_beat);
        end
      end
      prev_v = cfg_tvalid;
    end
  end

  task automatic pulse(input bit dc, input logic [CW-1:0] c, input bit dp, input logic [PW-1:0] p);
    @(negedge clk);
    corr = c; corr_vld = dc; poff = p; poff_vld = dp;
    if (dc) m_corr = c;
    if (dp) m_poff = p;
    @(negedge clk);
    corr_vld = 1'b0; poff_vld = 1'b0;
  endtask

  task automatic wait_hs(output bit ok);
    int n0;
    n0 = n_acc;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (n_acc != n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_settled(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (settled) break;
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (cfg_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b expected 0", cfg_tvalid); end
    tests++; if (cfg_tdata !== '0) begin fails++; $display("FAIL rst_tdata: got %h expected 0", cfg_tdata); end
    tests++; if (settled !== 1'b0) begin fails++; $display("FAIL rst_settled: got %b expected 0", settled); end
    tests++; if (nco_en !== 1'b0) begin fails++; $display("FAIL rst_nco_en: got %b expected 0", nco_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_initial_beat;
    bit ok;
    int n;
    @(negedge clk);
    base_inc = 32'h0CCC_CCCD; cfg_tready = 1'b1; enable = 1'b1;
    m_corr = '0; m_poff = '0;
    rst_n = 1'b1;
    wait_hs(ok);
    tests++; if (!ok) begin fails++; $display("FAIL init_hs: got timeout expected handshake"); end
    tests++; if (last_hs !== 64'h0000_0000_0CCC_CCCD) begin fails++; $display("FAIL init_tdata: got %h expected 00000000_0ccccccd", last_hs); end
    wait_settled(n);
    tests++; if (n != ST) begin fails++; $display("FAIL init_settle_lat: got %0d expected %0d", n, ST); end
    tests++; if (nco_en !== 1'b1) begin fails++; $display("FAIL init_nco_en: got %b expected 1", nco_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL init_busy: got %b expected 0", busy); end
  endtask

  task automatic test_neg_corr;
    bit ok;
    int n;
    pulse(1'b1, 16'hFFFF, 1'b0, '0);
    tests++; if (cfg_tvalid !== 1'b1) begin fails++; $display("FAIL neg_tvalid_lat: got %b expected 1", cfg_tvalid); end
    tests++; if (settled !== 1'b0) begin fails++; $display("FAIL neg_settled_fall: got %b expected 0", settled); end
    tests++; if (cfg_tdata !== 64'h0000_0000_0CCC_CBCD) begin fails++; $display("FAIL neg_pinc: got %h expected 00000000_0ccccbcd", cfg_tdata); end
    wait_hs(ok);
    tests++; if (!ok) begin fails++; $display("FAIL neg_hs: got timeout expected handshake"); end
    wait_settled(n);
    tests++; if (n != ST) begin fails++; $display("FAIL neg_settle_lat: got %0d expected %0d", n, ST); end
  endtask

  task automatic test_coalesce;
    int n0;
    @(negedge clk) cfg_tready = 1'b0;
    pulse(1'b1, 16'h0001, 1'b0, '0);
    n0 = n_acc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      corr_vld = 1'b0;
      if (i == 3) begin corr = 16'h0002; corr_vld = 1'b1; m_corr = 16'h0002; end
      if (i == 9) begin corr = 16'h0003; corr_vld = 1'b1; m_corr = 16'h0003; end
      tests++;
      if (cfg_tvalid !== 1'b1 || cfg_tdata !== 64'h0000_0000_0CCC_CDCD) begin
        fails++;
        $display("FAIL coal_hold: got v=%b %h expected v=1 00000000_0ccccdcd", cfg_tvalid, cfg_tdata);
      end
    end
    corr_vld = 1'b0;
    cfg_tready = 1'b1;
    repeat (3 * ST + 12) @(negedge clk);
    tests++; if (n_acc - n0 != 2) begin fails++; $display("FAIL coal_count: got %0d expected 2", n_acc - n0); end
    tests++; if (last_hs !== 64'h0000_0000_0CCC_CFCD) begin fails++; $display("FAIL coal_last: got %h expected 00000000_0ccccfcd", last_hs); end
    tests++; if (settled !== 1'b1) begin fails++; $display("FAIL coal_settled: got %b expected 1", settled); end
  endtask

  task automatic test_wrap;
    bit ok;
    int n;
    @(negedge clk) base_inc = 32'hFFFF_FF00;
    pulse(1'b1, 16'h0002, 1'b1, 32'h4000_0000);
    wait_hs(ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_hs: got timeout expected handshake"); end
    tests++; if (last_hs !== 64'h4000_0000_0000_0100) begin fails++; $display("FAIL wrap_tdata: got %h expected 40000000_00000100", last_hs); end
    wait_settled(n);
  endtask

  task automatic test_enable_pause;
    bit ok;
    int n;
    logic [2*PW-1:0] held;
    pulse(1'b1, 16'h0005, 1'b0, '0);
    wait_hs(ok);
    @(negedge clk) enable = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (settled !== 1'b0) begin fails++; $display("FAIL en_frozen: got %b expected 0", settled); end
    enable = 1'b1;
    wait_settled(n);
    tests++; if (5 + n != ST + 5) begin fails++; $display("FAIL en_settle_lat: got %0d expected %0d", 5 + n, ST + 5); end
    @(negedge clk) enable = 1'b0;
    #1;
    tests++; if (nco_en !== 1'b0 || settled !== 1'b1) begin fails++; $display("FAIL en_gate: got nco_en=%b settled=%b expected 0 1", nco_en, settled); end
    @(negedge clk) enable = 1'b1; cfg_tready = 1'b0;
    pulse(1'b1, 16'h0007, 1'b0, '0);
    held = model_beat(base_inc, 16'h0007, m_poff);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (cfg_tvalid !== 1'b1 || cfg_tdata !== held) begin
        fails++;
        $display("FAIL en_hold: got v=%b %h expected v=1 %h", cfg_tvalid, cfg_tdata, held);
      end
    end
    cfg_tready = 1'b1;
    wait_hs(ok);
    tests++; if (!ok) begin fails++; $display("FAIL en_hs_paused: got timeout expected handshake"); end
    @(negedge clk) enable = 1'b1;
    wait_settled(n);
    tests++; if (n != ST) begin fails++; $display("FAIL en_settle2: got %0d expected %0d", n, ST); end
  endtask

  task automatic test_reset_mid_send;
    bit ok;
    int n;
    @(negedge clk) cfg_tready = 1'b0;
    pulse(1'b1, 16'h0009, 1'b0, '0);
    tests++; if (cfg_tvalid !== 1'b1) begin fails++; $display("FAIL rms_pre: got %b expected 1", cfg_tvalid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (cfg_tvalid !== 1'b0 || nco_en !== 1'b0) begin fails++; $display("FAIL rms_drop: got v=%b nco_en=%b expected 0 0", cfg_tvalid, nco_en); end
    tests++; if (busy !== 1'b0 || settled !== 1'b0) begin fails++; $display("FAIL rms_flags: got busy=%b settled=%b expected 0 0", busy, settled); end
    m_corr = '0; m_poff = '0;
    @(negedge clk);
    rst_n = 1'b1; cfg_tready = 1'b1;
    wait_hs(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rms_hs: got timeout expected handshake"); end
    tests++; if (last_hs !== 64'h0000_0000_FFFF_FF00) begin fails++; $display("FAIL rms_restart: got %h expected 00000000_ffffff00", last_hs); end
    wait_settled(n);
    tests++; if (n != ST) begin fails++; $display("FAIL rms_settle: got %0d expected %0d", n, ST); end
  endtask

  task automatic test_random;
    logic [2*PW-1:0] want;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cfg_tready = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) base_inc = $urandom;
      pulse(1'b1, 16'($urandom), ($urandom_range(0, 2) == 0), $urandom);
      repeat ($urandom_range(0, 12)) begin
        @(negedge clk);
        cfg_tready = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    cfg_tready = 1'b1; enable = 1'b1;
    repeat (4 * ST + 20) @(negedge clk);
    want = model_beat(base_inc, m_corr, m_poff);
    tests++; if (last_hs !== want) begin fails++; $display("FAIL rnd_final: got %h expected %h", last_hs, want); end
    tests++; if (settled !== 1'b1 || cfg_tvalid !== 1'b0) begin fails++; $display("FAIL rnd_quiet: got settled=%b v=%b expected 1 0", settled, cfg_tvalid); end
  endtask

  initial begin
    test_reset;
    test_initial_beat;
    test_neg_corr;
    test_coalesce;
    test_wrap;
    test_enable_pause;
    test_reset_mid_send;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
